// File: rtl/oamdma_pkg.sv
// Shared state encoding and defaults for the $4014 OAM DMA engine.
// Optional DMC cycle stealing is enabled by defining OAMDMA_DMCSTEAL_EN.
package oamdma_pkg;

  localparam int OAMLEN_DEFAULT = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_ALIGN,
    ST_READ,
    ST_WRITE
`ifdef OAMDMA_DMCSTEAL_EN
    , ST_DMC
`endif
  } state_t;

endpackage

// File: rtl/oamdma.sv
// OAM DMA engine: halts the CPU and copies one CPU page into the sprite unit
// through $2004-style writes. Define OAMDMA_DMCSTEAL_EN to let DMC reads steal get cycles.
module oamdma
  import oamdma_pkg::*;
#(
  parameter int OAMLEN = OAMLEN_DEFAULT,
  parameter int ADDRW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cputick,
  input  logic             wr4014,
  input  logic [7:0]       regwdata,
  output logic             dmahalt,
  output logic             dmard,
  output logic [ADDRW-1:0] dmaaddr,
  input  logic [7:0]       dmardata,
  output logic             dmawr2004,
  output logic [7:0]       dmawdata,
  output logic             dmabusy
`ifdef OAMDMA_DMCSTEAL_EN
  ,
  input  logic             dmcreq,
  input  logic [ADDRW-1:0] dmcaddr,
  output logic             dmcack
`endif
);

  localparam logic [7:0] IDX_LAST = 8'(OAMLEN - 1);

  state_t           state_q, state_d;
  logic             parity_q;
  logic [7:0]       idx_q, idx_d;
  logic [7:0]       page_q, page_d;
  logic [7:0]       data_q;
  logic [ADDRW-1:0] addr_d;
  logic             rd_d;
`ifdef OAMDMA_DMCSTEAL_EN
  logic             steal_q, steal_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    page_d  = page_q;
`ifdef OAMDMA_DMCSTEAL_EN
    steal_d = steal_q || (dmcreq && (state_q == ST_READ || state_q == ST_HALT));
`endif
    case (state_q)
      ST_IDLE: begin
        if (wr4014) begin
          page_d  = regwdata;
          idx_d   = '0;
          state_d = ST_HALT;
        end
      end
      // parity_q is the parity of the HALT cycle; READ must land on an even cycle
      ST_HALT:  state_d = parity_q ? ST_READ : ST_ALIGN;
      ST_ALIGN: state_d = ST_READ;
      ST_READ:  state_d = ST_WRITE;
      ST_WRITE: begin
        idx_d   = (idx_q + 8'd1) & IDX_LAST;
        state_d = (idx_q == IDX_LAST) ? ST_IDLE : ST_READ;
      end
`ifdef OAMDMA_DMCSTEAL_EN
      ST_DMC:   state_d = ST_ALIGN;
`endif
      default:  state_d = ST_IDLE;
    endcase
`ifdef OAMDMA_DMCSTEAL_EN
    // A pending steal takes over the next get cycle; the OAM read retries after ALIGN
    if (state_d == ST_READ && steal_d) begin
      state_d = ST_DMC;
      steal_d = 1'b0;
    end
    if (state_d == ST_IDLE) steal_d = 1'b0;
`endif

    rd_d   = (state_d == ST_READ);
    addr_d = '0;
    if (state_d == ST_READ) addr_d = ADDRW'({page_d, idx_d});
`ifdef OAMDMA_DMCSTEAL_EN
    if (state_d == ST_DMC) begin
      rd_d   = 1'b1;
      addr_d = dmcaddr;
    end
`endif
  end

  // Outputs are registered from the next-state decode so they move only on cputick
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      parity_q  <= 1'b0;
      idx_q     <= '0;
      page_q    <= '0;
      data_q    <= '0;
      dmahalt   <= 1'b0;
      dmabusy   <= 1'b0;
      dmard     <= 1'b0;
      dmaaddr   <= '0;
      dmawr2004 <= 1'b0;
`ifdef OAMDMA_DMCSTEAL_EN
      steal_q   <= 1'b0;
      dmcack    <= 1'b0;
`endif
    end else if (cputick) begin
      state_q   <= state_d;
      parity_q  <= ~parity_q;
      idx_q     <= idx_d;
      page_q    <= page_d;
      if (state_q == ST_READ) data_q <= dmardata;
      dmahalt   <= (state_d != ST_IDLE);
      dmabusy   <= (state_d != ST_IDLE);
      dmard     <= rd_d;
      dmaaddr   <= addr_d;
      dmawr2004 <= (state_d == ST_WRITE);
`ifdef OAMDMA_DMCSTEAL_EN
      steal_q   <= steal_d;
      dmcack    <= (state_d == ST_DMC);
`endif
    end
  end

  assign dmawdata = data_q;

endmodule

// File: tb/tb_oamdma.sv
// Directed bench for oamdma: page copies at both accept parities, OAM offset wrap,
// ignored retrigger, mid-run reset and (with OAMDMA_DMCSTEAL_EN) a DMC steal.
module tb_oamdma;

  logic        clk;
  logic        reset;
  logic        cputick;
  logic        wr4014;
  logic [7:0]  regwdata;
  logic        dmahalt;
  logic        dmard;
  logic [15:0] dmaaddr;
  logic [7:0]  dmardata;
  logic        dmawr2004;
  logic [7:0]  dmawdata;
  logic        dmabusy;
  logic        ack_s;
`ifdef OAMDMA_DMCSTEAL_EN
  logic        dmcreq;
  logic [15:0] dmcaddr;
  logic        dmcack;
  assign ack_s = dmcack;
`else
  assign ack_s = 1'b0;
`endif

  oamdma dut (
    .clk       (clk),
    .reset     (reset),
    .cputick   (cputick),
    .wr4014    (wr4014),
    .regwdata  (regwdata),
    .dmahalt   (dmahalt),
    .dmard     (dmard),
    .dmaaddr   (dmaaddr),
    .dmardata  (dmardata),
    .dmawr2004 (dmawr2004),
    .dmawdata  (dmawdata),
    .dmabusy   (dmabusy)
`ifdef OAMDMA_DMCSTEAL_EN
    ,
    .dmcreq    (dmcreq),
    .dmcaddr   (dmcaddr),
    .dmcack    (dmcack)
`endif
  );

  int          checks = 0;
  int          failures = 0;
  int          tcount = 0;
  int          div = 0;
  int          halt_cnt, rd_cnt, wr_cnt, dmc_cnt, addr_err, overlap;
  logic [15:0] first_addr, dmc_addr_seen;
  logic [7:0]  exp_page;
  logic [7:0]  oam_ptr;
  logic [7:0]  oam [256];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // CPU cycle enable: one clk in three
  initial begin
    cputick = 1'b0;
    forever begin
      @(negedge clk);
      div = (div == 2) ? 0 : div + 1;
      cputick = (div == 0);
    end
  end

  // Per-CPU-cycle monitor: memory model, OAM model and event counters
  initial begin
    dmardata = 8'h00;
    forever begin
      @(posedge clk);
      if (reset) tcount = 0;
      else if (cputick) begin
        tcount++;
        #1;
        if (dmahalt) halt_cnt++;
        if (dmard && dmawr2004) overlap++;
        if (dmard && !ack_s) begin
          if (dmaaddr !== {exp_page, rd_cnt[7:0]}) addr_err++;
          if (rd_cnt == 0) first_addr = dmaaddr;
          rd_cnt++;
          dmardata = dmaaddr[7:0] ^ 8'hA5;
        end
        if (ack_s) begin
          dmc_cnt++;
          dmc_addr_seen = dmaaddr;
          dmardata = 8'hEE;
        end
        if (dmawr2004) begin
          oam[oam_ptr] = dmawdata;
          oam_ptr++;
          wr_cnt++;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic waitTick();
    @(posedge clk);
    while (!cputick) @(posedge clk);
    #2;
  endtask

  task automatic clearCounters(input logic [7:0] page, input logic [7:0] oam_start);
    halt_cnt = 0; rd_cnt = 0; wr_cnt = 0; dmc_cnt = 0; addr_err = 0; overlap = 0;
    first_addr = 16'hFFFF; dmc_addr_seen = 16'hFFFF;
    exp_page = page;
    oam_ptr = oam_start;
    for (int i = 0; i < 256; i++) oam[i] = 8'h00;
  endtask

  // Issue a $4014 write in a cycle of the requested parity, then expect busy
  task automatic applyStimulus(input string tag, input logic [7:0] page, input bit par);
    if (tcount[0] != par) waitTick();
    wr4014 = 1'b1;
    regwdata = page;
    waitTick();
    wr4014 = 1'b0;
    checkOutput({tag, "_busy_rise"}, {dmabusy, dmahalt, dmard}, 3'b110);
  endtask

  task automatic waitDone(input string tag);
    int n = 0;
    while (dmabusy && n < 800) begin
      waitTick();
      n++;
    end
    checkOutput({tag, "_done"}, dmabusy, 1'b0);
  endtask

  task automatic checkOam(input string tag, input logic [7:0] off);
    int e = 0;
    logic [7:0] a;
    for (int i = 0; i < 256; i++) begin
      a = i[7:0] + off;
      if (oam[a] !== (i[7:0] ^ 8'hA5)) e++;
    end
    checkOutput(tag, e, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    wr4014 = 1'b0;
    regwdata = 8'h00;
`ifdef OAMDMA_DMCSTEAL_EN
    dmcreq = 1'b0;
    dmcaddr = 16'h4123;
`endif
    clearCounters(8'h00, 8'h00);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("rst_flags", {dmahalt, dmabusy, dmard, dmawr2004}, 4'b0000);
    checkOutput("rst_addr", dmaaddr, 16'h0000);
    checkOutput("rst_wdata", dmawdata, 8'h00);
    @(negedge clk) reset = 1'b0;

    // Even accept: HALT lands odd, no ALIGN
    clearCounters(8'h02, 8'h00);
    applyStimulus("t1", 8'h02, 1'b0);
    waitDone("t1");
    checkOutput("t1_halt", halt_cnt, 513);
    checkOutput("t1_rd", rd_cnt, 256);
    checkOutput("t1_wr", wr_cnt, 256);
    checkOutput("t1_addr_err", addr_err, 0);
    checkOutput("t1_overlap", overlap, 0);
    checkOam("t1_oam", 8'h00);

    // Odd accept: one ALIGN cycle
    clearCounters(8'h02, 8'h00);
    applyStimulus("t2", 8'h02, 1'b1);
    waitDone("t2");
    checkOutput("t2_halt", halt_cnt, 514);
    checkOutput("t2_first_addr", first_addr, 16'h0200);
    checkOutput("t2_wr", wr_cnt, 256);

    // Sprite-unit address starting at $10 wraps around OAM
    clearCounters(8'h07, 8'h10);
    applyStimulus("t3", 8'h07, 1'b0);
    waitDone("t3");
    checkOam("t3_oam_off", 8'h10);
    checkOutput("t3_addr_err", addr_err, 0);

    // $4014 write during an active transfer is ignored
    clearCounters(8'h03, 8'h00);
    applyStimulus("t4", 8'h03, 1'b1);
    n = 0;
    while (rd_cnt < 100 && n < 400) begin waitTick(); n++; end
    checkOutput("t4_reach_idx100", rd_cnt, 100);
    wr4014 = 1'b1;
    regwdata = 8'h05;
    waitTick();
    wr4014 = 1'b0;
    waitDone("t4");
    checkOutput("t4_rd", rd_cnt, 256);
    checkOutput("t4_wr", wr_cnt, 256);
    checkOutput("t4_addr_err", addr_err, 0);
    checkOutput("t4_halt", halt_cnt, 514);
    repeat (3) waitTick();
    checkOutput("t4_no_restart", dmabusy, 1'b0);

    // Reset mid-transfer, then restart from idx 0
    clearCounters(8'h04, 8'h00);
    applyStimulus("t5", 8'h04, 1'b0);
    n = 0;
    while (wr_cnt < 37 && n < 400) begin waitTick(); n++; end
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t5_rst_flags", {dmahalt, dmabusy, dmard, dmawr2004}, 4'b0000);
    checkOutput("t5_rst_addr", dmaaddr, 16'h0000);
    reset = 1'b0;
    repeat (5) waitTick();
    checkOutput("t5_wr_frozen", wr_cnt, 37);
    clearCounters(8'h06, 8'h00);
    applyStimulus("t5r", 8'h06, 1'b0);
    waitDone("t5r");
    checkOutput("t5r_first_addr", first_addr, 16'h0600);
    checkOutput("t5r_wr", wr_cnt, 256);
    checkOutput("t5r_halt", halt_cnt, 513);
    checkOam("t5r_oam", 8'h00);

`ifdef OAMDMA_DMCSTEAL_EN
    // DMC request during the READ of idx 10 steals the next get cycle
    clearCounters(8'h08, 8'h00);
    applyStimulus("t6", 8'h08, 1'b0);
    n = 0;
    while (rd_cnt < 11 && n < 100) begin waitTick(); n++; end
    dmcreq = 1'b1;
    waitTick();
    dmcreq = 1'b0;
    waitDone("t6");
    checkOutput("t6_halt", halt_cnt, 515);
    checkOutput("t6_dmc_cnt", dmc_cnt, 1);
    checkOutput("t6_dmc_addr", dmc_addr_seen, 16'h4123);
    checkOutput("t6_wr", wr_cnt, 256);
    checkOutput("t6_addr_err", addr_err, 0);
    checkOam("t6_oam", 8'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
